// File: rtl/lane_fifo_pkg.sv
// Shared configuration for the multi-lane FIFO.
// Holds the default lane word width, lane count, depth and stall counter
// width, plus the lane word and lane mask types used by producer and
// consumer logic built around the FIFO.
package lane_fifo_pkg;

  localparam int DATA_W  = 8;
  localparam int LANES   = 4;
  localparam int DEPTH   = 8;
  localparam int STALL_W = 16;

  typedef logic [DATA_W-1:0] lane_word_t;
  typedef logic [LANES-1:0]  lane_mask_t;

endpackage

// File: rtl/pkg_width_lane_fifo_ctrl.sv
// Control path of the multi-lane FIFO.
// Owns the read/write pointers, the occupancy level, the full/empty flags
// and the saturating stall counter. The storage itself lives in the top.
//
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   clear            synchronous flush, overrides push and pop
//   in_valid         producer offers an entry
//   out_ready        consumer takes the head entry
//   in_ready         FIFO not full
//   out_valid        FIFO not empty
//   push, pop        qualified transfer strobes for the storage
//   wr_ptr, rd_ptr   storage indices
//   level            occupancy 0..DEPTH
//   stall_cnt        saturating count of cycles with in_valid && !in_ready
module lane_fifo_ctrl #(
  parameter int DEPTH   = lane_fifo_pkg::DEPTH,
  parameter int LVL_W   = $clog2(DEPTH + 1),
  parameter int STALL_W = lane_fifo_pkg::STALL_W,
  parameter int PTR_W   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               clear,
  input  logic               in_valid,
  input  logic               out_ready,
  output logic               in_ready,
  output logic               out_valid,
  output logic               push,
  output logic               pop,
  output logic [PTR_W-1:0]   wr_ptr,
  output logic [PTR_W-1:0]   rd_ptr,
  output logic [LVL_W-1:0]   level,
  output logic [STALL_W-1:0] stall_cnt
);

  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic stall_hit;

  // Ready/valid derive only from the registered level, so there is neither a
  // same-cycle bypass when empty nor a pass-through when full.
  assign in_ready  = (level != FULL_LVL);
  assign out_valid = (level != '0);

  // clear suppresses both transfers so the storage sees no write either.
  assign push      = in_valid && in_ready && !clear;
  assign pop       = out_valid && out_ready && !clear;
  assign stall_hit = in_valid && !in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      stall_cnt <= '0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      stall_cnt <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap by plain overflow.
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase

      if (stall_hit && (stall_cnt != '1)) stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end

endmodule

// File: rtl/pkg_width_lane_fifo.sv
// Multi-lane synchronous FIFO. Each entry carries LANES words plus a lane
// enable mask; disabled lanes are stored as zero. valid/ready handshakes on
// both sides, fill level, saturating stall counter and synchronous clear.
//
// Ports:
//   clk, rstn     clock, asynchronous active-low reset
//   clear         synchronous flush (pointers, level, stall counter)
//   in_valid      producer has an entry      in_ready     FIFO accepts it
//   in_data       LANES lane words           in_lane_en   lane enable mask
//   out_valid     head entry available       out_ready    consumer takes it
//   out_data      head lane words (0 when empty)
//   out_lane_en   head lane mask (0 when empty)
//   level         occupancy 0..DEPTH
//   stall_cnt     saturating count of cycles with in_valid && !in_ready
module pkg_width_lane_fifo #(
  parameter int DATA_W  = lane_fifo_pkg::DATA_W,
  parameter int LANES   = lane_fifo_pkg::LANES,
  parameter int DEPTH   = lane_fifo_pkg::DEPTH,
  parameter int LVL_W   = $clog2(DEPTH + 1),
  parameter int STALL_W = lane_fifo_pkg::STALL_W
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data [LANES],
  input  logic [LANES-1:0]   in_lane_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data [LANES],
  output logic [LANES-1:0]   out_lane_en,
  output logic [LVL_W-1:0]   level,
  output logic [STALL_W-1:0] stall_cnt
);

  import lane_fifo_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);

  logic              push;
  logic              pop;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  logic [DATA_W-1:0] mem_data [DEPTH][LANES];
  logic [LANES-1:0]  mem_mask [DEPTH];

  lane_fifo_ctrl #(
    .DEPTH   (DEPTH),
    .LVL_W   (LVL_W),
    .STALL_W (STALL_W),
    .PTR_W   (PTR_W)
  ) u_ctrl (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (clear),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .push      (push),
    .pop       (pop),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
    .level     (level),
    .stall_cnt (stall_cnt)
  );

  // NOTE: the storage is reset so that every entry is defined zero after
  // reset; this forces flops rather than RAM, which suits a shallow FIFO.
  // clear leaves contents alone because the output gating hides them.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int e = 0; e < DEPTH; e++) begin
        mem_mask[e] <= '0;
        for (int l = 0; l < LANES; l++) mem_data[e][l] <= '0;
      end
    end else if (push) begin
      mem_mask[wr_ptr] <= in_lane_en;
      for (int l = 0; l < LANES; l++)
        mem_data[wr_ptr][l] <= in_lane_en[l] ? in_data[l] : '0;
    end
  end

  // NOTE: every output gets a value on every path, so no latch is inferred.
  always_comb begin
    out_lane_en = out_valid ? mem_mask[rd_ptr] : '0;
    for (int l = 0; l < LANES; l++)
      out_data[l] = out_valid ? mem_data[rd_ptr][l] : '0;
  end

endmodule

// File: tb/tb_pkg_width_lane_fifo.sv
// Directed self-checking bench for pkg_width_lane_fifo (default parameters:
// 8-bit words, 4 lanes, depth 8, 16-bit stall counter).
module tb_pkg_width_lane_fifo;

  logic        clk;
  logic        rstn;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data [4];
  logic [3:0]  in_lane_en;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data [4];
  logic [3:0]  out_lane_en;
  logic [3:0]  level;
  logic [15:0] stall_cnt;

  int tests;
  int fails;

  pkg_width_lane_fifo dut (
    .clk         (clk),
    .rstn        (rstn),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_lane_en  (in_lane_en),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_lane_en (out_lane_en),
    .level       (level),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lanes(input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] d2, input logic [7:0] d3);
    in_data[0] = d0;
    in_data[1] = d1;
    in_data[2] = d2;
    in_data[3] = d3;
  endtask

  task automatic check_lanes(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3);
    check({tag, "_l0"}, 32'(out_data[0]), 32'(e0));
    check({tag, "_l1"}, 32'(out_data[1]), 32'(e1));
    check({tag, "_l2"}, 32'(out_data[2]), 32'(e2));
    check({tag, "_l3"}, 32'(out_data[3]), 32'(e3));
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    rstn       = 1'b0;
    clear      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    in_lane_en = 4'h0;
    set_lanes(8'h00, 8'h00, 8'h00, 8'h00);

    // Reset state.
    #3;
    check("rst_level", 32'(level), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_lane_en", 32'(out_lane_en), 0);
    check("rst_stall", 32'(stall_cnt), 0);
    check_lanes("rst_data", 8'h00, 8'h00, 8'h00, 8'h00);
    #9 rstn = 1'b1;   // released at t=12, away from the edges at 5/15
    step();

    // Fill to full with {11,22,33,44}.
    set_lanes(8'h11, 8'h22, 8'h33, 8'h44);
    in_lane_en = 4'hF;
    in_valid   = 1'b1;
    for (int i = 0; i < 8; i++) step();
    check("full_level", 32'(level), 8);
    check("full_in_ready", 32'(in_ready), 0);
    check("full_out_valid", 32'(out_valid), 1);
    check_lanes("full_data", 8'h11, 8'h22, 8'h33, 8'h44);

    // Hold in_valid while full for 5 cycles, offering different data.
    set_lanes(8'hEE, 8'hEE, 8'hEE, 8'hEE);
    for (int i = 0; i < 5; i++) step();
    in_valid = 1'b0;
    check("stall_cnt5", 32'(stall_cnt), 5);
    check("stall_level", 32'(level), 8);

    // Drain: every entry must still be the original one.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_valid", 32'(out_valid), 1);
      check("drain_l0", 32'(out_data[0]), 32'h11);
      check("drain_l3", 32'(out_data[3]), 32'h44);
      step();
    end
    out_ready = 1'b0;
    check("drained_level", 32'(level), 0);
    check("drained_valid", 32'(out_valid), 0);
    check_lanes("drained_data", 8'h00, 8'h00, 8'h00, 8'h00);
    check("drained_stall_hold", 32'(stall_cnt), 5);

    // Masked push into an empty FIFO; no same-cycle bypass.
    set_lanes(8'hAA, 8'hBB, 8'hCC, 8'hDD);
    in_lane_en = 4'b0101;
    in_valid   = 1'b1;
    #1 check("nobypass_valid", 32'(out_valid), 0);
    step();
    in_valid = 1'b0;
    check("mask_valid", 32'(out_valid), 1);
    check("mask_lane_en", 32'(out_lane_en), 32'h5);
    check_lanes("mask_data", 8'hAA, 8'h00, 8'hCC, 8'h00);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("mask_pop_level", 32'(level), 0);

    // Preload F0,F1,F2, then 10 cycles of simultaneous push/pop of 0..9.
    in_lane_en = 4'hF;
    in_valid   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_lanes(8'hF0 + 8'(i), 8'h0, 8'h0, 8'hF0 + 8'(i));
      step();
    end
    check("pp_pre_level", 32'(level), 3);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_lanes(8'(i), 8'h0, 8'h0, 8'(i));
      check("pp_level", 32'(level), 3);
      check("pp_head_l0", 32'(out_data[0]), (i < 3) ? 32'hF0 + 32'(i) : 32'(i - 3));
      check("pp_head_l3", 32'(out_data[3]), (i < 3) ? 32'hF0 + 32'(i) : 32'(i - 3));
      step();
    end
    out_ready = 1'b0;
    check("pp_post_level", 32'(level), 3);
    check("pp_post_head", 32'(out_data[0]), 32'h07);

    // Two more pushes to level 5, then clear with push and pop requested.
    for (int i = 0; i < 2; i++) step();
    check("clr_pre_level", 32'(level), 5);
    clear     = 1'b1;
    out_ready = 1'b1;
    step();
    clear     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("clr_level", 32'(level), 0);
    check("clr_out_valid", 32'(out_valid), 0);
    check("clr_in_ready", 32'(in_ready), 1);
    check("clr_stall", 32'(stall_cnt), 0);
    check("clr_lane_en", 32'(out_lane_en), 0);
    check_lanes("clr_data", 8'h00, 8'h00, 8'h00, 8'h00);

    // Level 4, then asynchronous reset pulse between clock edges.
    in_valid = 1'b1;
    set_lanes(8'h51, 8'h52, 8'h53, 8'h54);
    for (int i = 0; i < 4; i++) step();
    in_valid = 1'b0;
    check("ar_pre_level", 32'(level), 4);
    #1 rstn = 1'b0;
    #1;
    check("ar_level", 32'(level), 0);
    check("ar_out_valid", 32'(out_valid), 0);
    check("ar_in_ready", 32'(in_ready), 1);
    check_lanes("ar_data", 8'h00, 8'h00, 8'h00, 8'h00);
    #4 rstn = 1'b1;
    step();
    set_lanes(8'h77, 8'h78, 8'h79, 8'h7A);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("ar_push_valid", 32'(out_valid), 1);
    check("ar_push_level", 32'(level), 1);
    check_lanes("ar_push_data", 8'h77, 8'h78, 8'h79, 8'h7A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
